supl_seq: RTL and testbench



---
 rtl/supl_seq.sv | 127 ++++++++++++
 tb/tb_supl_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/supl_seq.sv
// supl_seq: per-start operand sequencer. LOAD computes the XOR word and logic flag, SCAN sums zero-bit indices of a.
// o_drop is registered: it is high the cycle after the edge that saw i_start outside IDLE.
module supl_seq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_en,
  input  logic        i_sw,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_drop,
  output logic [31:0] o_xor0,
  output logic        o_o,
  output logic [8:0]  o_sum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_en;
  logic        r_sw;
  logic [8:0]  r_acc;
  logic [4:0]  r_idx;

  logic        w_bit_zero;
  logic [8:0]  w_acc_next;

  function automatic logic [31:0] f_xor_word(input logic [31:0] a, input logic [31:0] b,
                                             input logic en);
    logic [31:0] res;
    if (en) begin
      res = a ^ (b >> 4);
    end else begin
      res = {a[31:16] ^ a[15:0], b[31:16] ^ b[15:0]};
    end
    return res;
  endfunction

  function automatic logic f_logic_flag(input logic a0, input logic b0);
    return ~(((a0 & b0) ^ b0) | a0);
  endfunction

  // Zero-bit index contribution of the bit currently under the scan index
  always_comb begin
    w_bit_zero = ~r_a[r_idx];
    if (w_bit_zero) begin
      w_acc_next = r_acc + {4'd0, r_idx};
    end else begin
      w_acc_next = r_acc;
    end
  end

  // Sequencer state, operand latches, scan accumulator and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_a     <= 32'h0;
      r_b     <= 32'h0;
      r_en    <= 1'b0;
      r_sw    <= 1'b0;
      r_acc   <= 9'd0;
      r_idx   <= 5'd0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_drop  <= 1'b0;
      o_xor0  <= 32'h0;
      o_o     <= 1'b0;
      o_sum   <= 9'd0;
    end else begin
      o_done <= 1'b0;
      o_drop <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_en    <= i_en;
            r_sw    <= i_sw;
            o_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          o_drop <= i_start;
          if (r_sw) begin
            o_xor0 <= f_xor_word(r_a, r_b, r_en);
            o_o    <= f_logic_flag(r_a[0], r_b[0]);
          end
          r_acc   <= 9'd0;
          r_idx   <= 5'd0;
          r_state <= ST_SCAN;
        end
        ST_SCAN: begin
          o_drop <= i_start;
          r_acc  <= w_acc_next;
          // Bit 31 is folded in on the way into DONE so sum never shows a partial value
          if (r_idx == 5'd31) begin
            o_sum   <= w_acc_next;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end
        ST_DONE: begin
          o_drop  <= i_start;
          r_state <= ST_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_supl_seq.sv
// Directed bench for supl_seq: hand-computed vectors, drop behaviour and mid-scan reset.
module tb_supl_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        en;
  logic        sw;
  logic        busy;
  logic        done;
  logic        drop;
  logic [31:0] xor0;
  logic        o;
  logic [8:0]  sum;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int done_base;

  supl_seq dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_en    (en),
    .i_sw    (sw),
    .o_busy  (busy),
    .o_done  (done),
    .o_drop  (drop),
    .o_xor0  (xor0),
    .o_o     (o),
    .o_sum   (sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge after E+34.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic env,
                        input logic swv, input logic [31:0] exp_x, input logic exp_o,
                        input logic [8:0] exp_sum, input logic [8:0] prev_sum,
                        input string tag);
    a = av; b = bv; en = env; sw = swv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv; en = ~env; sw = ~swv;
    check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    check({tag, "_done_e0"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    check({tag, "_xor0"}, xor0, exp_x);
    check({tag, "_o"}, {31'd0, o}, {31'd0, exp_o});
    repeat (31) @(negedge clk);
    check({tag, "_done_e32"}, {31'd0, done}, 32'd0);
    check({tag, "_sum_hold"}, {23'd0, sum}, {23'd0, prev_sum});
    check({tag, "_busy_e32"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_done_e33"}, {31'd0, done}, 32'd1);
    check({tag, "_sum"}, {23'd0, sum}, {23'd0, exp_sum});
    check({tag, "_busy_e33"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_e34"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 32'h0; b = 32'h0; en = 1'b0; sw = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_drop", {31'd0, drop}, 32'd0);
    check("rst_xor0", xor0, 32'h0);
    check("rst_o", {31'd0, o}, 32'd0);
    check("rst_sum", {23'd0, sum}, 32'd0);
    // start coincident with reset must not be accepted
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);

    run_op(32'h0000FFFF, 32'h12345678, 1'b1, 1'b1, 32'h0123BA98, 1'b0, 9'd376, 9'd0,   "t1");
    run_op(32'hAAAA5555, 32'h0F0FF0F0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 9'd248, 9'd376, "t2");
    run_op(32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 9'd496, 9'd248, "t3a");
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 9'd0,   9'd496, "t3b");
    run_op(32'hFFFFFFFE, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b1, 9'd0,   9'd0,   "t4");

    // drop: start pulsed during SCAN and in the DONE cycle
    done_base = done_cnt;
    a = 32'h0000FFFF; b = 32'h12345678; en = 1'b1; sw = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("drp_idle_drop", {31'd0, drop}, 32'd0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("drp_scan_drop", {31'd0, drop}, 32'd1);
    @(negedge clk);
    check("drp_scan_drop_clr", {31'd0, drop}, 32'd0);
    repeat (27) @(negedge clk);
    check("drp_done", {31'd0, done}, 32'd1);
    check("drp_sum", {23'd0, sum}, 32'd376);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("drp_done_drop", {31'd0, drop}, 32'd1);
    check("drp_done_clr", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("drp_not_queued", {31'd0, busy}, 32'd0);
    check("drp_xor0", xor0, 32'h0123BA98);
    check("drp_o", {31'd0, o}, 32'd0);
    check("drp_done_count", done_cnt - done_base, 32'd1);

    // reset at SCAN index 10 discards the operation
    a = 32'hAAAA5555; b = 32'h0F0FF0F0; en = 1'b0; sw = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_base = done_cnt;
    repeat (11) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_xor0", xor0, 32'h0);
    check("mrst_o", {31'd0, o}, 32'd0);
    check("mrst_sum", {23'd0, sum}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clk);
    check("mrst_no_done", done_cnt - done_base, 32'd0);
    check("mrst_idle", {31'd0, busy}, 32'd0);

    run_op(32'hAAAA5555, 32'h0F0FF0F0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 9'd248, 9'd0, "post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
